sram_word_ctrl: RTL

//  Synchronous master for the 8-bit board SRAM, driven from FPGA-internal logic.
//  - Accepts 16-bit word read/write requests on a valid/ready handshake.
//  - Executes each request as two timed byte cycles: low byte, then high byte.
//  - Byte addresses: low byte at {addr,1'b0}, high byte at {addr,1'b1}, the same

---
 rtl/sram_word_ctrl_pkg.sv | 16 +
 rtl/sram_word_ctrl_pad_io.sv | 29 ++
 rtl/sram_word_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sram_word_ctrl_pkg.sv
// Shared definitions for the 8-bit board SRAM word controller: bus widths and FSM states.
package sram_word_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 19;
  localparam int unsigned SRAM_DATA_W = 8;
  localparam int unsigned WORD_ADDR_W = SRAM_ADDR_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO_ACC,
    ST_LO_END,
    ST_HI_ACC,
    ST_HI_END
  } state_e;

endpackage

// File: rtl/sram_word_ctrl_pad_io.sv
// SRAM data pad: registered output byte and output enable driving the tristate bus.
module sram_pad_io
  import sram_word_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SRAM_DATA_W-1:0] dout_d,
  input  logic                   oe_d,
  output logic [SRAM_DATA_W-1:0] din,
  inout  wire  [SRAM_DATA_W-1:0] pad
);

  logic [SRAM_DATA_W-1:0] dout_q;
  logic                   oe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      oe_q   <= oe_d;
    end
  end

  assign pad = oe_q ? dout_q : 'z;
  assign din = pad;

endmodule

// File: rtl/sram_word_ctrl.sv
// 16-bit word master for the 8-bit board SRAM (low byte then high byte).
// Optional `SRAM_BYTE_MASK_EN adds the req_be write byte-enable port.
module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WORD_ADDR_W-1:0] req_addr,
  input  logic [15:0]            req_wdata,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [1:0]             req_be,
`endif
  output logic                   rsp_valid,
  output logic [15:0]            rsp_rdata,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_D,
  output logic [SRAM_ADDR_W-1:0] SRAM_A,
  output logic                   SRAM_CS,
  output logic                   SRAM_OE,
  output logic                   SRAM_WE
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  state_e                 state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   wr_d, wr_q;
  logic [15:0]            wdata_d, wdata_q;
  logic [1:0]             be_d, be_q;
  logic [15:0]            rd_buf_d, rd_buf_q;
  logic [SRAM_ADDR_W-1:0] sram_a_d, sram_a_q;
  logic                   sram_cs_d, sram_cs_q;
  logic                   sram_oe_d, sram_oe_q;
  logic                   sram_we_d, sram_we_q;
  logic                   rsp_valid_d, rsp_valid_q;
  logic [15:0]            rsp_rdata_d, rsp_rdata_q;
  logic [SRAM_DATA_W-1:0] dout_d, din;
  logic                   doe_d;
  logic [1:0]             be_in;

`ifdef SRAM_BYTE_MASK_EN
  assign be_in = req_be;
`else
  assign be_in = 2'b11;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_buf_d    = rd_buf_q;
    sram_a_d    = sram_a_q;
    sram_cs_d   = sram_cs_q;
    sram_oe_d   = sram_oe_q;
    sram_we_d   = sram_we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    dout_d      = wdata_q[7:0];
    doe_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d      = req_we;
          wdata_d   = req_wdata;
          be_d      = be_in;
          sram_a_d  = {req_addr, 1'b0};
          sram_cs_d = 1'b0;
          sram_oe_d = req_we;
          sram_we_d = ~(req_we & be_in[0]);
          cnt_d     = '0;
          dout_d    = req_wdata[7:0];
          doe_d     = req_we;
          state_d   = ST_LO_ACC;
        end
      end
      ST_LO_ACC: begin
        doe_d = wr_q;
        if (cnt_q == WAIT_LAST) begin
          rd_buf_d[7:0] = din;
          sram_oe_d     = 1'b1;
          sram_we_d     = 1'b1;
          state_d       = ST_LO_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LO_END: begin
        sram_a_d[0] = 1'b1;
        sram_oe_d   = wr_q;
        sram_we_d   = ~(wr_q & be_q[1]);
        cnt_d       = '0;
        dout_d      = wdata_q[15:8];
        doe_d       = wr_q;
        state_d     = ST_HI_ACC;
      end
      ST_HI_ACC: begin
        dout_d = wdata_q[15:8];
        doe_d  = wr_q;
        if (cnt_q == WAIT_LAST) begin
          rd_buf_d[15:8] = din;
          sram_oe_d      = 1'b1;
          sram_we_d      = 1'b1;
          state_d        = ST_HI_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI_END: begin
        // Bytes are staged in rd_buf so rsp_rdata changes only when a read completes.
        sram_cs_d   = 1'b1;
        rsp_valid_d = 1'b1;
        if (!wr_q) rsp_rdata_d = rd_buf_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_buf_q    <= '0;
      sram_a_q    <= '0;
      sram_cs_q   <= 1'b1;
      sram_oe_q   <= 1'b1;
      sram_we_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_buf_q    <= rd_buf_d;
      sram_a_q    <= sram_a_d;
      sram_cs_q   <= sram_cs_d;
      sram_oe_q   <= sram_oe_d;
      sram_we_q   <= sram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  sram_pad_io u_pad (
    .clk    (clk),
    .reset  (reset),
    .dout_d (dout_d),
    .oe_d   (doe_d),
    .din    (din),
    .pad    (SRAM_D)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SRAM_A    = sram_a_q;
  assign SRAM_CS   = sram_cs_q;
  assign SRAM_OE   = sram_oe_q;
  assign SRAM_WE   = sram_we_q;

endmodule
